dvp_pixel_capture: RTL and testbench



---
 rtl/dvp_cam_pkg.sv | 17 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/dvp_pixel_capture.sv | 173 +++++++++++++++++
 tb/tb_dvp_pixel_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_cam_pkg.sv
// Shared definitions for the DVP camera receive path.
package dvp_cam_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StVsync = 2'd1,
        StFrame = 2'd2
    } cap_state_e;

    // Flag positions above the pixel data field in a FIFO entry: {sof, eol, data}.
    localparam int unsigned EOL_BIT = 0;
    localparam int unsigned SOF_BIT = 1;

    // RGB565 byte order on the wire: high byte arrives first.
    localparam bit HI_FIRST = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is accepted only with a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dvp_pixel_capture.sv
// DVP frame/line tracker and byte packer feeding a valid/ready pixel stream through a FIFO.
module dvp_pixel_capture #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PIXEL_W    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter bit          VSYNC_POL  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pclk_sync_i,
    input  logic               dvp_href_i,
    input  logic               dvp_vsync_i,
    input  logic [DATA_W-1:0]  dvp_d_i,
    output logic [PIXEL_W-1:0] pix_data_o,
    output logic               pix_sof_o,
    output logic               pix_eol_o,
    output logic               pix_valid_o,
    input  logic               pix_ready_i,
    output logic               ovf_o,
    input  logic               ovf_clr_i
);

    import dvp_cam_pkg::*;

    localparam int unsigned ENTRY_W = PIXEL_W + 2;

    logic               href_s_q, vsync_s_q, s_vld_q;
    logic [DATA_W-1:0]  d_s_q;

    cap_state_e         state_q, state_d;
    logic               phase_q, phase_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [PIXEL_W-1:0] pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               sof_arm_q, sof_arm_d;
    logic               ovf_q;

    logic               vs_act;
    logic [PIXEL_W-1:0] new_pix;
    logic               push;
    logic               push_eol;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full, fifo_empty;
    logic               pop;
    logic               drop;

    assign vs_act  = (vsync_s_q == VSYNC_POL);
    assign new_pix = HI_FIRST ? {hi_q, d_s_q} : {d_s_q, hi_q};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sof_arm_d  = sof_arm_q;
        push       = 1'b0;
        push_eol   = 1'b0;

        if (s_vld_q) begin
            unique case (state_q)
                StIdle: begin
                    if (vs_act) begin
                        state_d = StVsync;
                    end
                end
                StVsync: begin
                    if (!vs_act) begin
                        state_d   = StFrame;
                        sof_arm_d = 1'b1;
                    end
                end
                StFrame: begin
                    if (vs_act) begin
                        state_d    = StVsync;
                        phase_d    = 1'b0;
                        push       = pend_vld_q;
                        push_eol   = 1'b1;
                        pend_vld_d = 1'b0;
                    end else if (href_s_q) begin
                        if (!phase_q) begin
                            hi_d    = d_s_q;
                            phase_d = 1'b1;
                        end else begin
                            // The previous pixel is now known not to end the line.
                            phase_d    = 1'b0;
                            push       = pend_vld_q;
                            pend_d     = new_pix;
                            pend_vld_d = 1'b1;
                        end
                    end else begin
                        phase_d    = 1'b0;
                        push       = pend_vld_q;
                        push_eol   = 1'b1;
                        pend_vld_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (push) begin
            sof_arm_d = 1'b0;
        end
    end

    always_comb begin
        fifo_wdata                    = '0;
        fifo_wdata[PIXEL_W-1:0]       = pend_q;
        fifo_wdata[PIXEL_W + EOL_BIT] = push_eol;
        fifo_wdata[PIXEL_W + SOF_BIT] = sof_arm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            href_s_q   <= 1'b0;
            vsync_s_q  <= 1'b0;
            d_s_q      <= '0;
            s_vld_q    <= 1'b0;
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sof_arm_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s_vld_q <= pclk_sync_i;
            if (pclk_sync_i) begin
                href_s_q  <= dvp_href_i;
                vsync_s_q <= dvp_vsync_i;
                d_s_q     <= dvp_d_i;
            end
            state_q    <= state_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sof_arm_q  <= sof_arm_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign pop  = pix_valid_o & pix_ready_i;
    assign drop = push & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Gate with valid so stale FIFO storage never leaks out after reset.
    assign pix_valid_o = ~fifo_empty;
    assign pix_data_o  = pix_valid_o ? fifo_rdata[PIXEL_W-1:0] : '0;
    assign pix_eol_o   = pix_valid_o & fifo_rdata[PIXEL_W + EOL_BIT];
    assign pix_sof_o   = pix_valid_o & fifo_rdata[PIXEL_W + SOF_BIT];
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_dvp_pixel_capture.sv
// Directed bench for dvp_pixel_capture: framing, packing, overflow, reset and glitch rejection.
module tb_dvp_pixel_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pclk_sync = 1'b0;
    logic        dvp_href = 1'b0;
    logic        dvp_vsync = 1'b0;
    logic [7:0]  dvp_d = 8'h00;
    logic [15:0] pix_data;
    logic        pix_sof, pix_eol, pix_valid;
    logic        pix_ready = 1'b1;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } vec_t;

    logic [17:0] got_q[$];
    logic        prev_hold = 1'b0;
    logic [17:0] prev_word = '0;

    always #5 clk = ~clk;

    dvp_pixel_capture #(
        .DATA_W     (8),
        .PIXEL_W    (16),
        .FIFO_DEPTH (8),
        .VSYNC_POL  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pclk_sync_i (pclk_sync),
        .dvp_href_i  (dvp_href),
        .dvp_vsync_i (dvp_vsync),
        .dvp_d_i     (dvp_d),
        .pix_data_o  (pix_data),
        .pix_sof_o   (pix_sof),
        .pix_eol_o   (pix_eol),
        .pix_valid_o (pix_valid),
        .pix_ready_i (pix_ready),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
    always @(negedge clk) begin
        if (prev_hold) begin
            chk("hold_valid", {31'd0, pix_valid}, 32'd1);
            chk("hold_word", {14'd0, pix_sof, pix_eol, pix_data}, {14'd0, prev_word});
        end
        if (pix_valid && pix_ready && !rst) begin
            got_q.push_back({pix_sof, pix_eol, pix_data});
        end
        prev_hold = pix_valid && !pix_ready && !rst;
        prev_word = {pix_sof, pix_eol, pix_data};
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One DVP PCLK: a single sampling pulse, then glitch values between pulses.
    task automatic dvp(input logic h, input logic v, input logic [7:0] d);
        dvp_href  = h;
        dvp_vsync = v;
        dvp_d     = d;
        pclk_sync = 1'b1;
        step(1);
        pclk_sync = 1'b0;
        dvp_d     = 8'hFF;
        dvp_href  = ~h;
        dvp_vsync = ~v;
        step(2);
    endtask

    task automatic vsync_pulse();
        dvp(1'b0, 1'b1, 8'h00);
        dvp(1'b0, 1'b1, 8'h00);
        dvp(1'b0, 1'b0, 8'h00);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({tag, "_data"}, {16'd0, pix_data}, 32'd0);
        chk({tag, "_sof"}, {31'd0, pix_sof}, 32'd0);
        chk({tag, "_eol"}, {31'd0, pix_eol}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        vec_t frame_tab[9];
        vec_t reset_tab[2];

        frame_tab[0] = '{"f1_l1_p0", 16'h1234, 1'b1, 1'b0};
        frame_tab[1] = '{"f1_l1_p1", 16'h5678, 1'b0, 1'b1};
        frame_tab[2] = '{"f1_l2_p0", 16'h1234, 1'b0, 1'b0};
        frame_tab[3] = '{"f1_l2_p1", 16'h5678, 1'b0, 1'b1};
        frame_tab[4] = '{"odd_p0",   16'hA1A2, 1'b0, 1'b0};
        frame_tab[5] = '{"odd_p1",   16'hA3A4, 1'b0, 1'b1};
        frame_tab[6] = '{"phase_p0", 16'hB1B2, 1'b0, 1'b0};
        frame_tab[7] = '{"phase_p1", 16'hB3B4, 1'b0, 1'b1};
        frame_tab[8] = '{"f2_sof",   16'hC1C2, 1'b1, 1'b1};
        reset_tab[0] = '{"rst_p0",   16'hD1D2, 1'b1, 1'b0};
        reset_tab[1] = '{"rst_p1",   16'hD3D4, 1'b0, 1'b1};

        step(3);
        outputs_zero("reset");
        rst = 1'b0;
        step(2);

        // Line before any vsync: must be ignored.
        for (int i = 0; i < 6; i++) dvp(1'b1, 1'b0, 8'(8'h40 + i));
        dvp(1'b0, 1'b0, 8'h00);
        step(4);
        chk("pre_vsync_count", got_q.size(), 32'd0);
        chk("pre_vsync_valid", {31'd0, pix_valid}, 32'd0);

        vsync_pulse();
        for (int l = 0; l < 2; l++) begin
            dvp(1'b1, 1'b0, 8'h12);
            dvp(1'b1, 1'b0, 8'h34);
            dvp(1'b1, 1'b0, 8'h56);
            dvp(1'b1, 1'b0, 8'h78);
            dvp(1'b0, 1'b0, 8'h00);
        end
        for (int i = 0; i < 5; i++) dvp(1'b1, 1'b0, 8'(8'hA1 + i));
        dvp(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) dvp(1'b1, 1'b0, 8'(8'hB1 + i));
        dvp(1'b0, 1'b0, 8'h00);
        dvp(1'b0, 1'b1, 8'h00);
        dvp(1'b0, 1'b0, 8'h00);
        dvp(1'b1, 1'b0, 8'hC1);
        dvp(1'b1, 1'b0, 8'hC2);
        dvp(1'b0, 1'b0, 8'h00);
        step(5);

        chk("frame_count", got_q.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            logic [17:0] act;
            act = (i < got_q.size()) ? got_q[i] : 18'h3FFFF;
            chk(frame_tab[i].name, {14'd0, act},
                {14'd0, frame_tab[i].sof, frame_tab[i].eol, frame_tab[i].data});
        end

        // Overflow: 20 pixels into an 8-deep FIFO with the consumer stalled.
        got_q.delete();
        pix_ready = 1'b0;
        for (int i = 0; i < 40; i++) dvp(1'b1, 1'b0, 8'(i));
        dvp(1'b0, 1'b0, 8'h00);
        step(4);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("ovf_head_valid", {31'd0, pix_valid}, 32'd1);
        chk("ovf_head_data", {16'd0, pix_data}, 32'h0001);
        for (int c = 0; c < 24; c++) begin
            pix_ready = c[0];
            step(1);
        end
        pix_ready = 1'b1;
        step(2);
        chk("drain_count", got_q.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            logic [17:0] act;
            logic [17:0] exp;
            act = (k < got_q.size()) ? got_q[k] : 18'h3FFFF;
            exp = {2'b00, 8'(2 * k), 8'(2 * k + 1)};
            chk($sformatf("drain_%0d", k), {14'd0, act}, {14'd0, exp});
        end
        chk("drain_empty", {31'd0, pix_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);

        // Reset mid-line with three pixels queued.
        got_q.delete();
        pix_ready = 1'b0;
        for (int i = 0; i < 8; i++) dvp(1'b1, 1'b0, 8'(8'h60 + i));
        step(3);
        chk("pre_rst_valid", {31'd0, pix_valid}, 32'd1);
        rst = 1'b1;
        step(1);
        outputs_zero("mid_rst");
        rst = 1'b0;
        pix_ready = 1'b1;
        for (int i = 0; i < 4; i++) dvp(1'b1, 1'b0, 8'(8'h68 + i));
        dvp(1'b0, 1'b0, 8'h00);
        step(4);
        chk("post_rst_count", got_q.size(), 32'd0);
        vsync_pulse();
        for (int i = 0; i < 4; i++) dvp(1'b1, 1'b0, 8'(8'hD1 + i));
        dvp(1'b0, 1'b0, 8'h00);
        step(5);
        chk("resume_count", got_q.size(), 32'd2);
        for (int i = 0; i < 2; i++) begin
            logic [17:0] act;
            act = (i < got_q.size()) ? got_q[i] : 18'h3FFFF;
            chk(reset_tab[i].name, {14'd0, act},
                {14'd0, reset_tab[i].sof, reset_tab[i].eol, reset_tab[i].data});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
